// File: rtl/div_unit_if.sv
// EX-stage <-> divider connection: operands and request from EX, {remainder, quotient} and ready back.
interface div_unit_if #(
  parameter int DATA_WIDTH = 32
);

  logic                      signed_div_input;
  logic [DATA_WIDTH-1:0]     operand1_input;
  logic [DATA_WIDTH-1:0]     operand2_input;
  logic                      start_input;
  logic                      annul_input;
  logic [2*DATA_WIDTH-1:0]   result_output;
  logic                      ready_output;

  // EX side: issues the request and consumes the result
  modport master (
    output signed_div_input,
    output operand1_input,
    output operand2_input,
    output start_input,
    output annul_input,
    input  result_output,
    input  ready_output
  );

  // Divider side: responds to the request
  modport slave (
    input  signed_div_input,
    input  operand1_input,
    input  operand2_input,
    input  start_input,
    input  annul_input,
    output result_output,
    output ready_output
  );

endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for the EX stage.
// Divides operand magnitudes one quotient bit per clock, then fixes signs.
// Result is {remainder, quotient}; all outputs come straight from registers.
module div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input logic         clock,
  input logic         reset,
  div_unit_if.slave   bus
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           counter_q, counter_d;
  logic [DATA_WIDTH-1:0]   quot_q, quot_d;
  logic [DATA_WIDTH-1:0]   rem_q, rem_d;
  logic [DATA_WIDTH-1:0]   divisor_q, divisor_d;
  logic                    negQuot_q, negQuot_d;
  logic                    negRem_q, negRem_d;
  logic [2*DATA_WIDTH-1:0] result_q, result_d;
  logic                    ready_q, ready_d;

  logic                    op1Neg, op2Neg;
  logic [DATA_WIDTH-1:0]   absOp1, absOp2;
  logic [DATA_WIDTH:0]     shifted, trial;
  logic [DATA_WIDTH-1:0]   finalQuot, finalRem;

  // Operand magnitudes and the trial subtraction for the current iteration.
  // quot_q starts out holding the dividend and fills with quotient bits from the right.
  always_comb begin
    op1Neg    = bus.signed_div_input & bus.operand1_input[DATA_WIDTH-1];
    op2Neg    = bus.signed_div_input & bus.operand2_input[DATA_WIDTH-1];
    absOp1    = op1Neg ? (~bus.operand1_input + 1'b1) : bus.operand1_input;
    absOp2    = op2Neg ? (~bus.operand2_input + 1'b1) : bus.operand2_input;
    shifted   = {rem_q, quot_q[DATA_WIDTH-1]};
    trial     = shifted - {1'b0, divisor_q};
    finalQuot = negQuot_q ? (~quot_q + 1'b1) : quot_q;
    finalRem  = negRem_q ? (~rem_q + 1'b1) : rem_q;
  end

  // Next-state and datapath control for the FREE/BYZERO/ON/END sequence
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    negQuot_d = negQuot_q;
    negRem_d  = negRem_q;
    result_d  = result_q;
    ready_d   = ready_q;

    case (state_q)
      FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (bus.start_input && !bus.annul_input) begin
          quot_d    = absOp1;
          rem_d     = '0;
          divisor_d = absOp2;
          negQuot_d = op1Neg ^ op2Neg;
          negRem_d  = op1Neg;
          counter_d = '0;
          if (bus.operand2_input == '0) begin
            state_d = BYZERO;
          end else begin
            state_d = ON;
          end
        end
      end

      BYZERO: begin
        result_d = '0;
        ready_d  = 1'b1;
        state_d  = END;
      end

      ON: begin
        if (bus.annul_input) begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end else if (counter_q != CW'(DATA_WIDTH)) begin
          if (!trial[DATA_WIDTH]) begin
            rem_d  = trial[DATA_WIDTH-1:0];
            quot_d = {quot_q[DATA_WIDTH-2:0], 1'b1};
          end else begin
            rem_d  = shifted[DATA_WIDTH-1:0];
            quot_d = {quot_q[DATA_WIDTH-2:0], 1'b0};
          end
          counter_d = counter_q + CW'(1);
        end else begin
          result_d = {finalRem, finalQuot};
          ready_d  = 1'b1;
          state_d  = END;
        end
      end

      END: begin
        if (!bus.start_input) begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end

      default: begin
        state_d  = FREE;
        ready_d  = 1'b0;
        result_d = '0;
      end
    endcase
  end

  // State and datapath registers; reset returns everything to an idle, cleared divider
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= FREE;
      counter_q <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      negQuot_q <= 1'b0;
      negRem_q  <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      negQuot_q <= negQuot_d;
      negRem_q  <= negRem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.result_output = result_q;
  assign bus.ready_output  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: expectations go into a queue when a request is issued,
// and an independent monitor pops and compares each time ready rises.
module tb_div_unit;

  localparam int W = 32;

  typedef struct {
    logic [63:0] result;
    int          readyCycle;
    string       name;
  } expect_t;

  logic    clock = 1'b0;
  logic    reset;
  int      checks = 0;
  int      errors = 0;
  int      cycleCount = 0;
  expect_t expQ[$];
  expect_t curExp;
  logic    prevReady = 1'b0;

  div_unit_if #(.DATA_WIDTH(W)) bus ();

  div_unit #(.DATA_WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running clock
  always #5 clock = ~clock;

  // Edge counter used to timestamp when ready rises
  always @(posedge clock) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Issue one divide, hold start until ready, hold one more cycle, then release.
  // scramble changes the live operands after acceptance to prove they were latched.
  task automatic applyStimulus(input string name, input logic sgn,
                               input logic [31:0] op1, input logic [31:0] op2,
                               input logic [63:0] expResult, input bit isZero,
                               input bit scramble);
    int waited;
    @(negedge clock);
    bus.signed_div_input = sgn;
    bus.operand1_input   = op1;
    bus.operand2_input   = op2;
    bus.start_input      = 1'b1;
    bus.annul_input      = 1'b0;
    expQ.push_back('{expResult, cycleCount + 1 + (isZero ? 1 : 33), name});
    if (scramble) begin
      @(negedge clock);
      bus.operand1_input   = 32'hDEADBEEF;
      bus.operand2_input   = 32'h00000003;
      bus.signed_div_input = ~sgn;
    end
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (bus.ready_output !== 1'b1 && waited < 40);
    if (bus.ready_output !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s.timeout: got ready=%b expected 1 within 40 cycles", name, bus.ready_output);
    end
    @(negedge clock);
    checkOutput({name, ".holdReady"}, 64'(bus.ready_output), 64'd1);
    checkOutput({name, ".holdResult"}, bus.result_output, expResult);
    bus.start_input = 1'b0;
    @(negedge clock);
    checkOutput({name, ".dropReady"}, 64'(bus.ready_output), 64'd0);
    checkOutput({name, ".dropResult"}, bus.result_output, 64'd0);
  endtask

  // Monitor: on every rising ready, compare against the oldest outstanding expectation
  initial begin
    forever begin
      @(negedge clock);
      if (bus.ready_output === 1'b1 && !prevReady) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedReady: got ready=1 result=%h expected no result", bus.result_output);
        end else begin
          curExp = expQ.pop_front();
          checkOutput({curExp.name, ".result"}, bus.result_output, curExp.result);
          checkOutput({curExp.name, ".latency"}, 64'(cycleCount), 64'(curExp.readyCycle));
        end
      end
      prevReady = (bus.ready_output === 1'b1);
    end
  end

  // Hard stop in case something wedges
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no completion expected $finish before 1ms");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    reset                = 1'b1;
    bus.signed_div_input = 1'b0;
    bus.operand1_input   = '0;
    bus.operand2_input   = '0;
    bus.start_input      = 1'b0;
    bus.annul_input      = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("reset.ready", 64'(bus.ready_output), 64'd0);
    checkOutput("reset.result", bus.result_output, 64'd0);
    reset = 1'b0;

    applyStimulus("udiv100by7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 1'b0);
    applyStimulus("sdivNeg7by2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, 1'b0);
    applyStimulus("sdiv7byNeg2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 1'b0, 1'b0);
    applyStimulus("sdivNeg8byNeg3", 1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD, {32'hFFFFFFFE, 32'h00000002}, 1'b0, 1'b0);
    applyStimulus("divByZero", 1'b0, 32'h12345678, 32'd0, 64'h0, 1'b1, 1'b0);
    applyStimulus("udivMaxBy1", 1'b0, 32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF}, 1'b0, 1'b0);
    applyStimulus("udiv5by10", 1'b0, 32'd5, 32'd10, {32'd5, 32'd0}, 1'b0, 1'b0);
    applyStimulus("udivMinByMax", 1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h0}, 1'b0, 1'b0);

    // Abort after ten iterations; nothing may come back
    @(negedge clock);
    bus.signed_div_input = 1'b0;
    bus.operand1_input   = 32'd1000;
    bus.operand2_input   = 32'd3;
    bus.start_input      = 1'b1;
    repeat (11) @(negedge clock);
    bus.annul_input = 1'b1;
    @(negedge clock);
    checkOutput("annul.ready", 64'(bus.ready_output), 64'd0);
    checkOutput("annul.result", bus.result_output, 64'd0);
    bus.annul_input = 1'b0;
    bus.start_input = 1'b0;
    repeat (40) @(negedge clock);
    checkOutput("annul.quiet", 64'(bus.ready_output), 64'd0);
    applyStimulus("afterAnnul", 1'b0, 32'hFFFFFFFF, 32'h10, {32'hF, 32'h0FFFFFFF}, 1'b0, 1'b0);

    // Synchronous reset after twenty iterations
    @(negedge clock);
    bus.signed_div_input = 1'b0;
    bus.operand1_input   = 32'h12345678;
    bus.operand2_input   = 32'h11;
    bus.start_input      = 1'b1;
    repeat (21) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midReset.ready", 64'(bus.ready_output), 64'd0);
    checkOutput("midReset.result", bus.result_output, 64'd0);
    reset           = 1'b0;
    bus.start_input = 1'b0;
    repeat (40) @(negedge clock);
    checkOutput("midReset.quiet", 64'(bus.ready_output), 64'd0);
    applyStimulus("sdivMinByNeg1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 1'b0, 1'b0);

    // Operands change after acceptance; result must use the latched ones
    applyStimulus("latchedOps", 1'b0, 32'd1000, 32'd7, {32'd6, 32'd142}, 1'b0, 1'b1);

    // start together with annul in FREE must not be accepted
    @(negedge clock);
    bus.signed_div_input = 1'b0;
    bus.operand1_input   = 32'd100;
    bus.operand2_input   = 32'd7;
    bus.start_input      = 1'b1;
    bus.annul_input      = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checkOutput("startWithAnnul.ready", 64'(bus.ready_output), 64'd0);
    end
    bus.start_input = 1'b0;
    bus.annul_input = 1'b0;
    repeat (40) @(negedge clock);
    checkOutput("startWithAnnul.quiet", 64'(bus.ready_output), 64'd0);

    checkOutput("queueDrained", 64'(expQ.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
